mem_write_arbiter: RTL
======================

MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required before a button level is accepted.
REQ-002 Parameter MAX_WAIT, default 8: cycles a pending button write may be held off by the CPU before it is forced through.
REQ-003 Ports clk and rst_n: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 btn  input  3  raw active-low push buttons; btn[0] = write A, btn[1] = write B, btn[2] = clear pending.
REQ-005 cpu_we  input  1  CPU store request this cycle.
REQ-006 cpu_addr  input  8  CPU store address.
REQ-007 cpu_wdata  input  8  CPU store data.
REQ-008 cpu_stall  output  1  CPU store not accepted this cycle; CPU holds cpu_we/addr/wdata.
REQ-009 mem_we  output  1  registered data-memory write enable.
REQ-010 mem_addr  output  8  registered data-memory write address.
REQ-011 mem_wdata  output  8  registered data-memory write data.
REQ-012 btn_pending  output  2  registered pending flags for write A (bit 0) and write B (bit 1).

Function
REQ-013 Each btn bit SHALL pass a 2-flop synchronizer, then a per-bit debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-014 A press event SHALL be a debounced 1->0 transition; a held button generates exactly one event, and release generates none.
REQ-015 Write A SHALL use fixed addr 8'd6 and data 8'd9; write B SHALL use fixed addr 8'd0 and data 8'd8.
REQ-016 A press event SHALL set the matching pending flag; a flag that is already set stays set (no queueing beyond one deep).
REQ-017 A btn[2] press event SHALL clear both pending flags and both wait counters; if it coincides with an A/B press event, clear wins.
REQ-018 FSM states: IDLE (no pending), WAIT (a flag pending, CPU priority), FORCE (wait counter reached MAX_WAIT).
REQ-019 In IDLE and WAIT, a CPU store SHALL be granted whenever cpu_we=1: cpu_stall=0 and a write is issued next cycle.
REQ-020 In WAIT with cpu_we=0, the highest-priority pending flag (A over B) SHALL be granted and cleared.
REQ-021 The wait counter SHALL increment each WAIT cycle in which a button is not granted and saturate at MAX_WAIT; on reaching it, the FSM SHALL enter FORCE.
REQ-022 In FORCE, the button write SHALL be granted unconditionally, cpu_stall SHALL equal cpu_we, and the FSM SHALL return to WAIT or IDLE with the counter cleared.
REQ-023 cpu_stall SHALL be combinational from state and cpu_we and SHALL be 0 whenever cpu_we=0.
REQ-024 A granted write SHALL appear on mem_we/mem_addr/mem_wdata exactly one cycle after the grant, with one write per cycle at most.
REQ-025 mem_we SHALL be 0 in any cycle following no grant; mem_addr and mem_wdata hold their last values.
REQ-026 A press event arriving in the same cycle as the grant of that flag SHALL leave the flag set (re-arm).

Reset
REQ-027 While rst_n=0: mem_we=0, mem_addr=0, mem_wdata=0, btn_pending=0, FSM=IDLE, counters=0, synchronizers and debounced levels=1 (released).
REQ-028 Reset asserted mid-operation SHALL drop any pending or in-flight write; no write is issued in the first cycle after release.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the write A and write B address and data constants, and the button index constants.
REQ-030 Sub-module btn_debounce (synchronizer, counter and press-event output, one instance per button bit) SHALL be used.

Verification
REQ-031 btn[0] held low for 40 cycles, CPU idle -> exactly one mem_we pulse with addr 6 and data 9, DEBOUNCE_CYCLES+4 cycles or fewer after the press.
REQ-032 btn[0] bounces (toggling every 3 cycles for 30 cycles) then releases -> no write, btn_pending=0.
REQ-033 btn[1] press while cpu_we=1 continuously -> CPU writes pass with cpu_stall=0 for MAX_WAIT cycles, then one stall cycle and a write with addr 0 and data 8.
REQ-034 A and B press on the same cycle, CPU idle -> write addr 6 then write addr 0 on consecutive cycles.
REQ-035 btn[1] pending, then btn[2] press -> btn_pending=0 and no write issued.
REQ-036 rst_n pulsed low while btn_pending=2'b01 -> all outputs 0 and no write after release.

Source files
------------

// File: rtl/mem_write_arbiter_pkg.sv
// Shared definitions for the button/CPU data-memory write arbiter:
// FSM state encoding, fixed button write targets and button bit indices.
package mem_write_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_FORCE = 2'd2;

  localparam logic [7:0] WR_A_ADDR = 8'd6;
  localparam logic [7:0] WR_A_DATA = 8'd9;
  localparam logic [7:0] WR_B_ADDR = 8'd0;
  localparam logic [7:0] WR_B_DATA = 8'd8;

  localparam int BTN_A   = 0;
  localparam int BTN_B   = 1;
  localparam int BTN_CLR = 2;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  // Write A outranks write B whenever both are pending.
  function automatic wr_t btn_write(input logic [1:0] pending);
    wr_t w;
    if (pending[BTN_A]) begin
      w.addr = WR_A_ADDR;
      w.data = WR_A_DATA;
    end else begin
      w.addr = WR_B_ADDR;
      w.data = WR_B_DATA;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_write_arbiter_btn_debounce.sv
// One active-low push button: 2-flop synchronizer, stability counter and a
// single-cycle press pulse on each accepted released->pressed change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          settle;

  assign settle = (sync_q2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // NOTE: synchronizer and level reset to 1 (released) so reset release is never seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync_q2;
        cnt   <= '0;
        press <= ~sync_q2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates data-memory writes between CPU stores and two debounced
// push-button writes; the CPU has priority until a button has waited MAX_WAIT cycles.
module mem_write_arbiter
  import mem_write_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_WAIT        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_stall,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic [1:0] btn_pending
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [2:0]    press;
  state_t        state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [1:0]    pend_n, grant_mask;
  logic          cpu_grant, btn_grant;
  wr_t           bw;

  for (genvar i = 0; i < 3; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn[i]),
      .press (press[i])
    );
  end

  assign cpu_stall = (state == ST_FORCE) && cpu_we;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cpu_grant = 1'b0;
    btn_grant = 1'b0;
    state_n   = state;
    wait_n    = wait_cnt;
    bw        = btn_write(btn_pending);

    case (state)
      ST_IDLE:  cpu_grant = cpu_we;
      ST_WAIT: begin
        cpu_grant = cpu_we;
        btn_grant = !cpu_we;
      end
      ST_FORCE: btn_grant = 1'b1;
      default: ;
    endcase

    grant_mask = btn_grant ? (btn_pending[BTN_A] ? 2'b01 : 2'b10) : 2'b00;
    // A press landing on its own grant re-arms the flag; clear overrides everything.
    pend_n     = (btn_pending & ~grant_mask) | press[BTN_B:BTN_A];
    if (press[BTN_CLR]) pend_n = 2'b00;

    if (pend_n == 2'b00) begin
      state_n = ST_IDLE;
      wait_n  = '0;
    end else if (btn_grant || state == ST_IDLE) begin
      state_n = ST_WAIT;
      wait_n  = '0;
    end else if (wait_cnt >= WW'(MAX_WAIT - 1)) begin
      state_n = ST_FORCE;
      wait_n  = WW'(MAX_WAIT);
    end else begin
      state_n = ST_WAIT;
      wait_n  = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      btn_pending <= 2'b00;
      mem_we      <= 1'b0;
      mem_addr    <= 8'd0;
      mem_wdata   <= 8'd0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      btn_pending <= pend_n;
      mem_we      <= btn_grant || cpu_grant;
      if (btn_grant) begin
        mem_addr  <= bw.addr;
        mem_wdata <= bw.data;
      end else if (cpu_grant) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
    end
  end

endmodule
